// File: rtl/bus_arbiter.sv
// bus_arbiter
// Shares one single-outstanding memory port between an instruction fetch
// unit (IFU) and a load/store unit (LSU).
//
// Each requester issues one-cycle reqValid pulses. A pulse is captured into
// that requester's pending slot. The slot stays occupied while its request
// waits and while it is in flight, and it clears on the matching memory
// response. The FSM (IDLE, BUSY_IFU, BUSY_LSU) grants one slot at a time.
//
// mem_reqValid is a one-cycle pulse, registered from the grant decision. The
// granted fields stay on mem_addr/size/wen/wdata/wmask until the next grant.
// They are therefore stable from mem_reqValid until mem_respValid.
//
// Responses are steered combinationally. While BUSY_X, mem_respValid drives
// X_respValid. mem_rdata feeds both rdata outputs directly.
//
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   ifu_reqValid/ifu_addr        IFU request pulse and fetch address
//   ifu_respValid/ifu_rdata      IFU response pulse and fetched word
//   lsu_reqValid/addr/size/wen/wdata/wmask   LSU request pulse and fields
//   lsu_respValid/lsu_rdata      LSU response pulse and load data
//   mem_reqValid/addr/size/wen/wdata/wmask   memory request pulse and fields
//   mem_respValid/mem_rdata      memory response pulse and read data
//
// Build option:
//   ARB_LSU_PRIORITY_EN  when defined, a tie always goes to the LSU and no
//                        last-grant register exists. The default build
//                        breaks ties round-robin.
module bus_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_reqValid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_respValid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_reqValid,
    input  logic [31:0] lsu_addr,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,
    output logic        mem_reqValid,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_size,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_respValid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IFU = 2'd1,
        BUSY_LSU = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic        ifu_pend_q;
    logic [31:0] ifu_addr_q;
    logic        lsu_pend_q;
    logic [31:0] lsu_addr_q;
    logic [1:0]  lsu_size_q;
    logic        lsu_wen_q;
    logic [31:0] lsu_wdata_q;
    logic [3:0]  lsu_wmask_q;

    logic        mem_req_q;
    logic [31:0] mem_addr_q;
    logic [1:0]  mem_size_q;
    logic        mem_wen_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wmask_q;

`ifndef ARB_LSU_PRIORITY_EN
    // Set when the LSU won the most recent contested decision.
    logic        last_lsu_q;
`endif

    logic        ifu_done, lsu_done;
    logic        ifu_take, lsu_take;
    logic        ifu_avail, lsu_avail;
    logic        contest, tie_lsu;
    logic        grant_ifu, grant_lsu;
    logic [31:0] ifu_addr_eff;
    logic [31:0] lsu_addr_eff;
    logic [1:0]  lsu_size_eff;
    logic        lsu_wen_eff;
    logic [31:0] lsu_wdata_eff;
    logic [3:0]  lsu_wmask_eff;

    // A response only counts for the current owner, so a stray response in
    // IDLE (or one arriving after a reset) has no effect.
    assign ifu_done = (state_q == BUSY_IFU) && mem_respValid;
    assign lsu_done = (state_q == BUSY_LSU) && mem_respValid;

    // A pulse is accepted into a free slot. It is also accepted into a slot
    // that frees in this same cycle, so a requester can re-request on its own
    // response. A pulse into a busy slot is dropped.
    assign ifu_take = ifu_reqValid && (!ifu_pend_q || ifu_done);
    assign lsu_take = lsu_reqValid && (!lsu_pend_q || lsu_done);

    // Requests visible to this cycle's decision. A pulse arriving now counts
    // already; that is what gives the one-cycle latency from IDLE.
    assign ifu_avail = ifu_take || (ifu_pend_q && !ifu_done);
    assign lsu_avail = lsu_take || (lsu_pend_q && !lsu_done);

    assign ifu_addr_eff  = ifu_take ? ifu_addr  : ifu_addr_q;
    assign lsu_addr_eff  = lsu_take ? lsu_addr  : lsu_addr_q;
    assign lsu_size_eff  = lsu_take ? lsu_size  : lsu_size_q;
    assign lsu_wen_eff   = lsu_take ? lsu_wen   : lsu_wen_q;
    assign lsu_wdata_eff = lsu_take ? lsu_wdata : lsu_wdata_q;
    assign lsu_wmask_eff = lsu_take ? lsu_wmask : lsu_wmask_q;

    // Both requesters compete only in IDLE. When a transaction completes, the
    // other requester (if waiting) is served next without contention.
    assign contest = (state_q == IDLE) && ifu_avail && lsu_avail;

`ifdef ARB_LSU_PRIORITY_EN
    assign tie_lsu = 1'b1;
`else
    assign tie_lsu = !last_lsu_q;
`endif

    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        state_d   = state_q;
        case (state_q)
            IDLE: begin
                if (contest) begin
                    grant_lsu = tie_lsu;
                    grant_ifu = !tie_lsu;
                end else begin
                    grant_ifu = ifu_avail;
                    grant_lsu = lsu_avail;
                end
            end
            BUSY_IFU: begin
                if (ifu_done) begin
                    grant_lsu = lsu_avail;
                    if (!lsu_avail) state_d = IDLE;
                end
            end
            BUSY_LSU: begin
                if (lsu_done) begin
                    grant_ifu = ifu_avail;
                    if (!ifu_avail) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant_ifu) begin
            state_d = BUSY_IFU;
        end else if (grant_lsu) begin
            state_d = BUSY_LSU;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ifu_pend_q  <= 1'b0;
            ifu_addr_q  <= 32'h0;
            lsu_pend_q  <= 1'b0;
            lsu_addr_q  <= 32'h0;
            lsu_size_q  <= 2'b00;
            lsu_wen_q   <= 1'b0;
            lsu_wdata_q <= 32'h0;
            lsu_wmask_q <= 4'h0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_size_q  <= 2'b00;
            mem_wen_q   <= 1'b0;
            mem_wdata_q <= 32'h0;
            mem_wmask_q <= 4'h0;
`ifndef ARB_LSU_PRIORITY_EN
            last_lsu_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;

            if (ifu_take) begin
                ifu_pend_q <= 1'b1;
                ifu_addr_q <= ifu_addr;
            end else if (ifu_done) begin
                ifu_pend_q <= 1'b0;
            end

            if (lsu_take) begin
                lsu_pend_q  <= 1'b1;
                lsu_addr_q  <= lsu_addr;
                lsu_size_q  <= lsu_size;
                lsu_wen_q   <= lsu_wen;
                lsu_wdata_q <= lsu_wdata;
                lsu_wmask_q <= lsu_wmask;
            end else if (lsu_done) begin
                lsu_pend_q <= 1'b0;
            end

            mem_req_q <= grant_ifu || grant_lsu;
            if (grant_ifu) begin
                mem_addr_q  <= ifu_addr_eff;
                mem_size_q  <= 2'b10;
                mem_wen_q   <= 1'b0;
                mem_wdata_q <= 32'h0;
                mem_wmask_q <= 4'h0;
            end else if (grant_lsu) begin
                mem_addr_q  <= lsu_addr_eff;
                mem_size_q  <= lsu_size_eff;
                mem_wen_q   <= lsu_wen_eff;
                mem_wdata_q <= lsu_wdata_eff;
                mem_wmask_q <= lsu_wmask_eff;
            end

`ifndef ARB_LSU_PRIORITY_EN
            if (contest) last_lsu_q <= grant_lsu;
`endif
        end
    end

    assign mem_reqValid  = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign mem_size      = mem_size_q;
    assign mem_wen       = mem_wen_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;

    assign ifu_respValid = ifu_done;
    assign lsu_respValid = lsu_done;
    assign ifu_rdata     = mem_rdata;
    assign lsu_rdata     = mem_rdata;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-high; ports SHALL be named clock and reset.
REQ-002 Port list (name direction width meaning), SHALL be exactly:
- clock  in  1  system clock
- reset  in  1  async active-high reset
- ifu_reqValid  in  1  IFU fetch request pulse
- ifu_addr  in  32  fetch address
- ifu_respValid  out  1  fetch response pulse
- ifu_rdata  out  32  fetched word
- lsu_reqValid  in  1  LSU request pulse
- lsu_addr  in  32  LSU address
- lsu_size  in  2  access size
- lsu_wen  in  1  write enable
- lsu_wdata  in  32  store data
- lsu_wmask  in  4  byte mask
- lsu_respValid  out  1  LSU response pulse
- lsu_rdata  out  32  load data
- mem_reqValid  out  1  memory request pulse
- mem_addr  out  32  memory address
- mem_size  out  2  access size
- mem_wen  out  1  write enable
- mem_wdata  out  32  store data
- mem_wmask  out  4  byte mask
- mem_respValid  in  1  memory response pulse
- mem_rdata  in  32  memory read data

REQ-003 The block SHALL have no parameters.

Function
REQ-004 Requesters SHALL issue one-cycle reqValid pulses; on a pulse the arbiter SHALL latch all request fields into a per-requester pending slot (IFU: addr only, fixed size 2'b10, wen=0, wmask=0).
REQ-005 The state machine SHALL have exactly three states: IDLE, BUSY_IFU, BUSY_LSU; at most one memory transaction SHALL be outstanding.
REQ-006 In IDLE with at least one pending slot, the arbiter SHALL select the winner, drive a one-cycle mem_reqValid on the next clock with the winner's latched fields, and enter BUSY_<winner>.
REQ-007 A request pulse arriving in IDLE SHALL produce mem_reqValid exactly one cycle later (latency 1).
REQ-008 mem_addr/size/wen/wdata/wmask SHALL hold the granted fields stable from mem_reqValid until mem_respValid.
REQ-009 In BUSY_X, mem_respValid SHALL combinationally drive X_respValid in the same cycle, and mem_rdata SHALL drive ifu_rdata and lsu_rdata directly; the non-owner respValid SHALL stay 0.
REQ-010 On mem_respValid the winner's pending slot SHALL clear; if the other slot is pending, its mem_reqValid SHALL be issued on the next clock (back-to-back, no idle cycle), otherwise the state SHALL return to IDLE.
REQ-011 A request from the requester not owning the bus SHALL be latched and served after the current transaction, never dropped.
REQ-012 A request pulse from a requester whose slot is already pending or in flight SHALL be ignored.
REQ-013 A request pulse in the same cycle as that requester's own mem_respValid SHALL be latched as a new pending request.
REQ-014 Default arbitration SHALL be round-robin: when both slots are pending at a decision point, the requester not granted last SHALL win.
REQ-015 mem_respValid in IDLE SHALL be ignored.

Reset
REQ-016 Reset SHALL force IDLE, clear both pending slots, set last-grant to LSU (IFU wins the first tie), and drive all mem_* outputs and both respValid outputs to 0.
REQ-017 Reset mid-transaction SHALL abandon the transaction; a late mem_respValid SHALL be ignored per REQ-015.

Configuration
REQ-018 With ARB_LSU_PRIORITY_EN defined, ties SHALL always grant LSU (fixed priority), and the last-grant register SHALL not be implemented; without it, REQ-014 round-robin SHALL apply.

Verification
REQ-019 Scenario: IFU pulse addr=0x8000_0000 in IDLE -> mem_reqValid at +1 with addr 0x8000_0000, size 2, wen 0; mem_respValid with rdata 0x0010_0073 -> ifu_respValid=1 and ifu_rdata=0x0010_0073 in the same cycle.
REQ-020 Scenario: LSU store addr=0x1000, wdata=0xDEAD_BEEF, wmask=0xF, size 2 -> mem fields match and hold until response; lsu_respValid pulses once.
REQ-021 Scenario: IFU and LSU pulse in the same cycle after reset -> IFU granted first, LSU issued the cycle after IFU response; repeating the tie grants LSU first (round-robin); with ARB_LSU_PRIORITY_EN, LSU is granted first both times.
REQ-022 Scenario: LSU pulse while BUSY_IFU -> no mem_reqValid until IFU response, then LSU mem_reqValid on the next cycle.
REQ-023 Scenario: reset asserted in BUSY_LSU, then mem_respValid after reset release -> no respValid output, state IDLE, and the next IFU pulse is served normally.
